// File: rtl/char_stream_pkg.sv
// rtl/char_stream_pkg.sv - shared types and constants for the character-stream UART transmitter
package char_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_START_BIT = 3'd3,
        ST_DATA_BITS = 3'd4,
        ST_STOP_BIT  = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    localparam int         CLKS_PER_BIT_DEFAULT = 434;
    localparam logic [7:0] CHAR_NUL             = 8'h00;
    localparam int         FRAME_BITS           = 10;
    localparam int         DATA_BITS_N          = 8;

    function automatic logic is_nul(input logic [7:0] b);
        return b == CHAR_NUL;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - baud counter producing one bit_tick per CLKS_PER_BIT clocks
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // clear holds cnt at 0 and LAST >= 1, so no tick can leak out while cleared
    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/char_stream_uart_tx.sv
// rtl/char_stream_uart_tx.sv - streams the output character buffer as UART 8N1 (optional CHAR_STREAM_STOP_ON_NUL_EN)
module char_stream_uart_tx
    import char_stream_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH        = 100,
    parameter int ADDRW        = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [ADDRW-1:0] count,
    output logic [ADDRW-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] char_idx
);

    localparam logic [ADDRW:0] DEPTH_N  = (ADDRW+1)'(DEPTH);
    localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS_N - 1);

    state_t         state, state_next;
    logic [ADDRW:0] n_q;
    logic [7:0]     shift_q;
    logic [2:0]     bit_cnt;
    logic           bit_tick;
    logic           timer_clear;
    logic           load_nul;
    logic [ADDRW:0] n_clamped;
    logic [ADDRW:0] next_idx;
    logic           more_chars;

    // one extra bit so that DEPTH == 2**ADDRW still fits without wrapping
    assign n_clamped  = ({1'b0, count} > DEPTH_N) ? DEPTH_N : {1'b0, count};
    assign next_idx   = {1'b0, rd_addr} + (ADDRW+1)'(1);
    assign more_chars = (next_idx < n_q);

`ifdef CHAR_STREAM_STOP_ON_NUL_EN
    assign load_nul = is_nul(rd_data);
`else
    assign load_nul = 1'b0;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_clear = 1'b1;
        tx          = 1'b1;
        busy        = (state != ST_IDLE);
        done        = (state == ST_FINISH);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (n_clamped == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = load_nul ? ST_FINISH : ST_START_BIT;
            end
            ST_START_BIT: begin
                timer_clear = 1'b0;
                tx          = 1'b0;
                if (bit_tick) begin
                    state_next = ST_DATA_BITS;
                end
            end
            ST_DATA_BITS: begin
                timer_clear = 1'b0;
                tx          = shift_q[0];
                if (bit_tick && bit_cnt == LAST_BIT) begin
                    state_next = ST_STOP_BIT;
                end
            end
            ST_STOP_BIT: begin
                timer_clear = 1'b0;
                if (bit_tick) begin
                    state_next = more_chars ? ST_FETCH : ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // rd_addr only advances while more_chars holds, so it stays at or below n-1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_q      <= '0;
            rd_addr  <= '0;
            char_idx <= '0;
            shift_q  <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_q     <= n_clamped;
                        rd_addr <= '0;
                    end
                end
                ST_LOAD: begin
                    shift_q  <= rd_data;
                    char_idx <= rd_addr;
                    bit_cnt  <= '0;
                end
                ST_DATA_BITS: begin
                    if (bit_tick) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_STOP_BIT: begin
                    if (bit_tick && more_chars) begin
                        rd_addr <= rd_addr + ADDRW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_stream_uart_tx.sv
// tb/tb_char_stream_uart_tx.sv - scoreboard bench for char_stream_uart_tx
module tb_char_stream_uart_tx;

    localparam int CPB    = 4;
    localparam int FRAME  = 10 * CPB + 2;

    typedef struct {
        logic [9:0] line;
        int         start_cyc;
        logic [6:0] chidx;
        logic [6:0] raddr;
    } frame_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] count = '0;
    logic [6:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       tx;
    logic       busy;
    logic       done;
    logic [6:0] char_idx;

    logic [7:0] mem [0:127];
    frame_t     rx_q[$];
    logic [7:0] exp_q[$];
    int         cycle = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [9:0] mon_line = '1;
    int         mon_start = 0;
    logic [6:0] mon_ch = '0;
    logic [6:0] mon_ra = '0;

    char_stream_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(100), .ADDRW(7)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .count    (count),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx       (tx),
        .busy     (busy),
        .done     (done),
        .char_idx (char_idx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cycle   <= cycle + 1;
        rd_data <= mem[rd_addr];
    end

    // UART receiver: samples mid-bit and pushes each completed frame
    always @(negedge clock) begin
        if (reset) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy  <= 1'b1;
                mon_cnt   <= 1;
                mon_start <= cycle;
                mon_ch    <= char_idx;
                mon_ra    <= rd_addr;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt % CPB == CPB / 2)
                mon_line[4'(mon_cnt / CPB)] <= tx;
            if (mon_cnt == CPB * 9 + CPB / 2) begin
                rx_q.push_back(frame_t'{{tx, mon_line[8:0]}, mon_start, mon_ch, mon_ra});
                mon_busy <= 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_xfer(input int cnt, input int bound, output int t_s, output int busy_cyc,
                            output int done_n, output int done_cyc, output int addr_max,
                            output int low_n, output bit timed_out);
        busy_cyc = 0; done_n = 0; done_cyc = -1; addr_max = 0; low_n = 0; timed_out = 1'b1;
        @(negedge clock);
        count = 7'(cnt);
        start = 1'b1;
        t_s   = cycle;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin done_n++; done_cyc = cycle; end
            if (int'(rd_addr) > addr_max) addr_max = int'(rd_addr);
            if (tx === 1'b0) low_n++;
            if (done_n > 0 && busy === 1'b0 && done === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (rd_addr !== 7'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        n_checks++; if (char_idx !== 7'd0) begin n_fail++; $display("FAIL reset_char_idx: got %0d expected 0", char_idx); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single;
        int t_s, bc, dn, dc, am, ln; bit to;
        frame_t f;
        mem[0] = 8'h41;
        rx_q.delete(); exp_q.delete();
        exp_q.push_back(8'h41);
        run_xfer(1, 200, t_s, bc, dn, dc, am, ln, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: got timeout expected done"); end
        n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL single_frames: got %0d expected 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            f = rx_q.pop_front();
            n_checks++;
            if (f.line !== {1'b1, exp_q.pop_front(), 1'b0}) begin
                n_fail++; $display("FAIL single_line: got %b expected %b", f.line, 10'b1010000010);
            end
            n_checks++;
            if (f.start_cyc != t_s + 3) begin
                n_fail++; $display("FAIL single_start_latency: got %0d expected %0d", f.start_cyc - t_s, 3);
            end
        end
        n_checks++; if (bc != 43) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected 43", bc); end
        n_checks++; if (dn != 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d expected 1", dn); end
        n_checks++; if (dc != t_s + 43) begin n_fail++; $display("FAIL single_done_time: got %0d expected %0d", dc - t_s, 43); end
    endtask

    task automatic test_multi;
        int t_s, bc, dn, dc, am, ln; bit to;
        frame_t f;
        logic [7:0] e;
        mem[0] = "A"; mem[1] = "B"; mem[2] = "C";
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
        run_xfer(3, 400, t_s, bc, dn, dc, am, ln, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL multi_timeout: got timeout expected done"); end
        n_checks++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL multi_frames: got %0d expected 3", rx_q.size()); end
        for (int i = 0; i < 3 && rx_q.size() > 0; i++) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (f.line !== {1'b1, e, 1'b0}) begin n_fail++; $display("FAIL multi_byte%0d: got %b expected %b", i, f.line, {1'b1, e, 1'b0}); end
            n_checks++; if (f.start_cyc != t_s + 3 + FRAME * i) begin n_fail++; $display("FAIL multi_start%0d: got %0d expected %0d", i, f.start_cyc - t_s, 3 + FRAME * i); end
            n_checks++; if (f.raddr !== 7'(i)) begin n_fail++; $display("FAIL multi_rd_addr%0d: got %0d expected %0d", i, f.raddr, i); end
            n_checks++; if (f.chidx !== 7'(i)) begin n_fail++; $display("FAIL multi_char_idx%0d: got %0d expected %0d", i, f.chidx, i); end
        end
        n_checks++; if (dc != t_s + 1 + FRAME * 3) begin n_fail++; $display("FAIL multi_done_time: got %0d expected %0d", dc - t_s, 1 + FRAME * 3); end
        n_checks++; if (am != 2) begin n_fail++; $display("FAIL multi_rd_addr_max: got %0d expected 2", am); end
    endtask

    task automatic test_zero;
        int t_s, bc, dn, dc, am, ln; bit to;
        rx_q.delete(); exp_q.delete();
        run_xfer(0, 50, t_s, bc, dn, dc, am, ln, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout: got timeout expected done"); end
        n_checks++; if (ln != 0) begin n_fail++; $display("FAIL zero_tx_low: got %0d low cycles expected 0", ln); end
        n_checks++; if (bc != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 1", bc); end
        n_checks++; if (dn != 1 || dc != t_s + 1) begin n_fail++; $display("FAIL zero_done: got %0d pulses at +%0d expected 1 at +1", dn, dc - t_s); end
    endtask

    task automatic test_clamp;
        int t_s, bc, dn, dc, am, ln; bit to;
        int nf;
        frame_t f;
        logic [7:0] e;
        for (int i = 0; i < 128; i++) mem[i] = 8'((i * 37 + 5) % 255 + 1);
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 100; i++) exp_q.push_back(mem[i]);
        run_xfer(120, 6000, t_s, bc, dn, dc, am, ln, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL clamp_timeout: got timeout expected done"); end
        nf = rx_q.size();
        n_checks++; if (nf != 100) begin n_fail++; $display("FAIL clamp_frames: got %0d expected 100", nf); end
        for (int i = 0; i < nf && exp_q.size() > 0; i++) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (f.line !== {1'b1, e, 1'b0}) begin n_fail++; $display("FAIL clamp_byte%0d: got %b expected %b", i, f.line, {1'b1, e, 1'b0}); end
        end
        n_checks++; if (am != 99) begin n_fail++; $display("FAIL clamp_rd_addr_max: got %0d expected 99", am); end
        n_checks++; if (dn != 1 || dc != t_s + 1 + FRAME * 100) begin n_fail++; $display("FAIL clamp_done: got %0d pulses at +%0d expected 1 at +%0d", dn, dc - t_s, 1 + FRAME * 100); end
    endtask

    task automatic test_reset_midframe;
        int t_s, target, bc, dn, dc, am, ln; bit to;
        frame_t f;
        mem[0] = "A"; mem[1] = "B"; mem[2] = "C";
        rx_q.delete(); exp_q.delete();
        @(negedge clock);
        count = 7'd3;
        start = 1'b1;
        t_s   = cycle;
        @(negedge clock);
        start = 1'b0;
        // second cycle of data bit 2 of 'B' (0x42), which is a 0 on the line
        target = t_s + 3 + FRAME + CPB * 3 + 1;
        for (int i = 0; i < 500 && cycle < target; i++) @(negedge clock);
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_pre_tx: got %b expected 0", tx); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_pre_busy: got %b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_async_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midframe_async_busy: got %b expected 0", busy); end
        n_checks++; if (rd_addr !== 7'd0) begin n_fail++; $display("FAIL midframe_async_rd_addr: got %0d expected 0", rd_addr); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        rx_q.delete();
        exp_q.push_back(mem[0]);
        run_xfer(1, 200, t_s, bc, dn, dc, am, ln, to);
        n_checks++; if (to || rx_q.size() != 1) begin n_fail++; $display("FAIL midframe_restart_frames: got %0d expected 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            f = rx_q.pop_front();
            n_checks++; if (f.line !== {1'b1, exp_q[0], 1'b0}) begin n_fail++; $display("FAIL midframe_restart_byte: got %b expected %b", f.line, {1'b1, exp_q[0], 1'b0}); end
        end
        exp_q.delete();
    endtask

    task automatic test_nul;
        int t_s, bc, dn, dc, am, ln, n_exp; bit to;
        frame_t f;
        logic [7:0] e;
        mem[0] = "H"; mem[1] = "I"; mem[2] = 8'h00; mem[3] = "Z";
        rx_q.delete(); exp_q.delete();
`ifdef CHAR_STREAM_STOP_ON_NUL_EN
        n_exp = 2;
`else
        n_exp = 4;
`endif
        for (int i = 0; i < n_exp; i++) exp_q.push_back(mem[i]);
        run_xfer(4, 400, t_s, bc, dn, dc, am, ln, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL nul_timeout: got timeout expected done"); end
        n_checks++; if (rx_q.size() != n_exp) begin n_fail++; $display("FAIL nul_frames: got %0d expected %0d", rx_q.size(), n_exp); end
        for (int i = 0; i < n_exp && rx_q.size() > 0; i++) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (f.line !== {1'b1, e, 1'b0}) begin n_fail++; $display("FAIL nul_byte%0d: got %b expected %b", i, f.line, {1'b1, e, 1'b0}); end
        end
`ifdef CHAR_STREAM_STOP_ON_NUL_EN
        n_checks++; if (dc != t_s + 3 + FRAME * 2) begin n_fail++; $display("FAIL nul_done_time: got %0d expected %0d", dc - t_s, 3 + FRAME * 2); end
`else
        n_checks++; if (dc != t_s + 1 + FRAME * 4) begin n_fail++; $display("FAIL nul_done_time: got %0d expected %0d", dc - t_s, 1 + FRAME * 4); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_clamp();
        test_reset_midframe();
        test_nul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
